// File: rtl/rename_checkpoint_unit.sv
// Single-issue register rename stage with speculative and committed alias tables
// sharing one circular free list; flush rebuilds the speculative map in a single cycle.
module rename_checkpoint_unit #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int PHYS_W        = 6,
  parameter int ARCH_W        = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic [ARCH_W-1:0] rs1,
  input  logic [ARCH_W-1:0] rs2,
  input  logic [ARCH_W-1:0] rd,
  input  logic              rd_write,
  output logic [PHYS_W-1:0] phys_rs1,
  output logic [PHYS_W-1:0] phys_rs2,
  output logic [PHYS_W-1:0] phys_rd,
  output logic [PHYS_W-1:0] prev_phys_rd,
  input  logic              retire_valid,
  input  logic              retire_rd_write,
  input  logic [ARCH_W-1:0] retire_arch_rd,
  input  logic [PHYS_W-1:0] retire_phys_rd,
  input  logic [PHYS_W-1:0] retire_prev_phys_rd,
  input  logic              flush,
  output logic [PHYS_W:0]   free_count,
  output logic              overflow_err
);

  localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FL_DEPTH - 1);
  localparam logic [PHYS_W:0]  FL_FULL  = (PHYS_W + 1)'(FL_DEPTH);

  logic [PHYS_W-1:0] spec_rat   [NUM_ARCH_REGS];
  logic [PHYS_W-1:0] commit_rat [NUM_ARCH_REGS];
  logic [PHYS_W-1:0] fifo       [FL_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  commit_head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  commit_head_next;

  logic alloc;
  logic fire;
  logic retire_upd;
  logic commit_wr;
  logic push;

  // Pointers wrap explicitly so the free list depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    alloc            = rd_write && (rd != '0);
    rename_ready     = !flush && (!alloc || (free_count != '0));
    fire             = rename_valid && rename_ready && alloc;
    retire_upd       = retire_valid && retire_rd_write;
    commit_wr        = retire_upd && (retire_arch_rd != '0);
    push             = retire_upd && (free_count != FL_FULL);
    commit_head_next = push ? ptr_inc(commit_head) : commit_head;
    phys_rs1         = (rs1 == '0) ? '0 : spec_rat[rs1];
    phys_rs2         = (rs2 == '0) ? '0 : spec_rat[rs2];
    phys_rd          = alloc ? fifo[head] : '0;
    prev_phys_rd     = alloc ? spec_rat[rd] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        spec_rat[i]   <= PHYS_W'(i);
        commit_rat[i] <= PHYS_W'(i);
      end
      for (int j = 0; j < FL_DEPTH; j++) begin
        fifo[j] <= PHYS_W'(NUM_ARCH_REGS + j);
      end
      head         <= '0;
      commit_head  <= '0;
      tail         <= '0;
      free_count   <= FL_FULL;
      overflow_err <= 1'b0;
    end else begin
      if (commit_wr) begin
        commit_rat[retire_arch_rd] <= retire_phys_rd;
      end
      if (push) begin
        fifo[tail] <= retire_prev_phys_rd;
        tail       <= ptr_inc(tail);
      end
      if (retire_upd && !push) begin
        overflow_err <= 1'b1;
      end
      commit_head <= commit_head_next;

      // Flush sees this cycle's retire: both the committed map and commit_head are forwarded.
      if (flush) begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
          spec_rat[i] <= (commit_wr && (retire_arch_rd == ARCH_W'(i))) ? retire_phys_rd
                                                                       : commit_rat[i];
        end
        head       <= commit_head_next;
        free_count <= FL_FULL;
      end else begin
        if (fire) begin
          spec_rat[rd] <= fifo[head];
          head         <= ptr_inc(head);
        end
        case ({fire, push})
          2'b10:   free_count <= free_count - 1'b1;
          2'b01:   free_count <= free_count + 1'b1;
          default: free_count <= free_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rename_checkpoint_unit.sv
// Bench for rename_checkpoint_unit: directed scenarios plus random traffic checked
// against a queue-based model of the free list and a modelled in-order ROB.
module tb_rename_checkpoint_unit;

  logic       clk;
  logic       reset_n;
  logic       rename_valid;
  logic       rename_ready;
  logic [4:0] rs1, rs2, rd;
  logic       rd_write;
  logic [5:0] phys_rs1, phys_rs2, phys_rd, prev_phys_rd;
  logic       retire_valid, retire_rd_write;
  logic [4:0] retire_arch_rd;
  logic [5:0] retire_phys_rd, retire_prev_phys_rd;
  logic       flush;
  logic [6:0] free_count;
  logic       overflow_err;

  rename_checkpoint_unit dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rename_valid        (rename_valid),
    .rename_ready        (rename_ready),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .rd                  (rd),
    .rd_write            (rd_write),
    .phys_rs1            (phys_rs1),
    .phys_rs2            (phys_rs2),
    .phys_rd             (phys_rd),
    .prev_phys_rd        (prev_phys_rd),
    .retire_valid        (retire_valid),
    .retire_rd_write     (retire_rd_write),
    .retire_arch_rd      (retire_arch_rd),
    .retire_phys_rd      (retire_phys_rd),
    .retire_prev_phys_rd (retire_prev_phys_rd),
    .flush               (flush),
    .free_count          (free_count),
    .overflow_err        (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] arch;
    logic [5:0] phys;
    logic [5:0] prev;
  } rob_t;

  logic [5:0] m_spec   [32];
  logic [5:0] m_commit [32];
  logic [5:0] free_q   [$];
  rob_t       rob_q    [$];
  logic       m_err;

  logic       exp_ready, obs_ready;
  logic [5:0] exp_rs1, obs_rs1, exp_rs2, obs_rs2;
  logic [5:0] exp_prd, obs_prd, exp_prev, obs_prev;
  logic       exp_prd_known;
  logic [6:0] exp_fc, obs_fc;
  logic       exp_err, obs_err;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i]   = 6'(i);
      m_commit[i] = 6'(i);
    end
    free_q.delete();
    for (int j = 0; j < 32; j++) free_q.push_back(6'(32 + j));
    rob_q.delete();
    m_err = 1'b0;
  endfunction

  // One clock of stimulus: combinational outputs sampled at negedge, state after posedge.
  task automatic cycle(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic wr, input logic rv, input logic rwr,
                       input logic [4:0] rar, input logic [5:0] rp, input logic [5:0] rpp,
                       input logic fl);
    bit   alloc, rdy, fire;
    logic [5:0] tag;
    rename_valid = v; rs1 = a1; rs2 = a2; rd = d; rd_write = wr;
    retire_valid = rv; retire_rd_write = rwr; retire_arch_rd = rar;
    retire_phys_rd = rp; retire_prev_phys_rd = rpp; flush = fl;
    @(negedge clk);
    alloc = wr && (d != 0);
    rdy   = !fl && (!alloc || free_q.size() != 0);
    fire  = v && rdy && alloc;
    exp_ready     = rdy;
    exp_rs1       = (a1 == 0) ? 6'd0 : m_spec[a1];
    exp_rs2       = (a2 == 0) ? 6'd0 : m_spec[a2];
    exp_prd_known = !alloc || free_q.size() != 0;
    exp_prd       = (alloc && free_q.size() != 0) ? free_q[0] : 6'd0;
    exp_prev      = alloc ? m_spec[d] : 6'd0;
    obs_ready = rename_ready; obs_rs1 = phys_rs1; obs_rs2 = phys_rs2;
    obs_prd   = phys_rd;      obs_prev = prev_phys_rd;
    @(posedge clk);
    #1;
    if (rv && rwr) begin
      if (rar != 0) m_commit[rar] = rp;
      if (free_q.size() == 32) m_err = 1'b1;
      else begin
        free_q.push_back(rpp);
        if (rob_q.size() != 0) void'(rob_q.pop_front());
      end
    end
    if (fl) begin
      for (int i = 0; i < 32; i++) m_spec[i] = m_commit[i];
      for (int i = rob_q.size() - 1; i >= 0; i--) free_q.push_front(rob_q[i].phys);
      rob_q.delete();
    end else if (fire) begin
      tag = free_q.pop_front();
      rob_q.push_back('{arch: d, phys: tag, prev: m_spec[d]});
      m_spec[d] = tag;
    end
    exp_fc  = 7'(free_q.size());
    exp_err = m_err;
    obs_fc  = free_count;
    obs_err = overflow_err;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rename_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_write = 0;
    retire_valid = 0; retire_rd_write = 0; retire_arch_rd = 0;
    retire_phys_rd = 0; retire_prev_phys_rd = 0; flush = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rename_valid = 0; rs1 = 5'd7; rs2 = 5'd0; rd = 0; rd_write = 0;
    retire_valid = 0; retire_rd_write = 0; retire_arch_rd = 0;
    retire_phys_rd = 0; retire_prev_phys_rd = 0; flush = 0;
    @(negedge clk);
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL reset_free_count got %0d want 32", free_count); end
    checks++; if (rename_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", rename_ready); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", overflow_err); end
    checks++; if (phys_rs1 !== 6'd7) begin errors++; $display("FAIL reset_rs1_identity got %0d want 7", phys_rs1); end
    checks++; if (phys_rd !== 6'd0) begin errors++; $display("FAIL reset_phys_rd got %0d want 0", phys_rd); end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_rename();
    do_reset();
    cycle(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_prd !== 6'd32 || obs_prd !== exp_prd) begin errors++; $display("FAIL basic_phys_rd got %0d want 32", obs_prd); end
    checks++; if (obs_prev !== 6'd5) begin errors++; $display("FAIL basic_prev got %0d want 5", obs_prev); end
    checks++; if (obs_rs1 !== 6'd5) begin errors++; $display("FAIL basic_rs1 got %0d want 5", obs_rs1); end
    checks++; if (obs_rs2 !== 6'd0) begin errors++; $display("FAIL basic_rs2 got %0d want 0", obs_rs2); end
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_rs1 !== 6'd32) begin errors++; $display("FAIL basic_rs1_after got %0d want 32", obs_rs1); end
    checks++; if (obs_fc !== 7'd31 || obs_fc !== exp_fc) begin errors++; $display("FAIL basic_free_count got %0d want 31", obs_fc); end
  endtask

  task automatic test_exhaust_and_refill();
    rob_t e;
    logic [4:0] d;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      d = 5'(((i + 4) % 31) + 1);
      cycle(1, d, 0, d, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_prd !== 6'(32 + i) || obs_prd !== exp_prd || obs_prev !== exp_prev) begin
        errors++; $display("FAIL exhaust_alloc_%0d got tag %0d prev %0d want tag %0d prev %0d", i, obs_prd, obs_prev, 32 + i, exp_prev);
      end
    end
    checks++; if (obs_fc !== 7'd0) begin errors++; $display("FAIL exhaust_free_count got %0d want 0", obs_fc); end
    cycle(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL exhaust_ready_alloc got %0b want 0", obs_ready); end
    cycle(1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL exhaust_ready_nonalloc got %0b want 1", obs_ready); end
    e = rob_q[0];
    cycle(1, 0, 0, 9, 1, 1, 1, e.arch, e.phys, e.prev, 0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL refill_ready_same_cycle got %0b want 0", obs_ready); end
    checks++; if (obs_fc !== 7'd1) begin errors++; $display("FAIL refill_free_count got %0d want 1", obs_fc); end
    cycle(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_prd !== 6'd5 || obs_ready !== 1'b1) begin errors++; $display("FAIL refill_tag got %0d ready %0b want 5 ready 1", obs_prd, obs_ready); end
    checks++; if (obs_fc !== 7'd0) begin errors++; $display("FAIL refill_free_count_after got %0d want 0", obs_fc); end
  endtask

  task automatic test_flush_recovery();
    rob_t e;
    do_reset();
    cycle(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_prd !== 6'd33 || obs_prev !== 6'd32) begin errors++; $display("FAIL flush_second_alloc got %0d prev %0d want 33 prev 32", obs_prd, obs_prev); end
    e = rob_q[0];
    cycle(0, 0, 0, 0, 0, 1, 1, e.arch, e.phys, e.prev, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (obs_fc !== 7'd32) begin errors++; $display("FAIL flush_free_count got %0d want 32", obs_fc); end
    cycle(1, 3, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_rs1 !== 6'd32) begin errors++; $display("FAIL flush_spec_rat3 got %0d want 32", obs_rs1); end
    checks++; if (obs_prd !== 6'd33 || obs_prd !== exp_prd) begin errors++; $display("FAIL flush_next_alloc got %0d want 33", obs_prd); end
  endtask

  task automatic test_flush_with_retire();
    rob_t e;
    do_reset();
    cycle(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    e = rob_q[0];
    cycle(1, 0, 0, 10, 1, 1, 1, e.arch, e.phys, e.prev, 1);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flushret_ready got %0b want 0", obs_ready); end
    checks++; if (obs_fc !== 7'd32) begin errors++; $display("FAIL flushret_free_count got %0d want 32", obs_fc); end
    for (int r = 1; r < 32; r++) begin
      cycle(0, 5'(r), 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_rs1 !== m_commit[r]) begin errors++; $display("FAIL flushret_rat_%0d got %0d want %0d", r, obs_rs1, m_commit[r]); end
    end
    cycle(0, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_rs1 !== 6'd32 || obs_rs2 !== 6'd8) begin errors++; $display("FAIL flushret_committed got %0d/%0d want 32/8", obs_rs1, obs_rs2); end
    cycle(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_prd !== 6'd33) begin errors++; $display("FAIL flushret_next_alloc got %0d want 33", obs_prd); end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 0);
    checks++; if (obs_err !== 1'b1 || obs_err !== exp_err) begin errors++; $display("FAIL overflow_set got %0b want 1", obs_err); end
    checks++; if (obs_fc !== 7'd32) begin errors++; $display("FAIL overflow_free_count got %0d want 32", obs_fc); end
    cycle(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_prd !== 6'd32) begin errors++; $display("FAIL overflow_push_dropped got %0d want 32", obs_prd); end
    idle();
    idle();
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %0b want 1", obs_err); end
    // asynchronous reset in the middle of a cycle
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (overflow_err !== 1'b0 || free_count !== 7'd32) begin errors++; $display("FAIL async_reset got err %0b fc %0d want 0 32", overflow_err, free_count); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1, 4, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_rs1 !== 6'd4 || obs_prd !== 6'd32) begin errors++; $display("FAIL async_reset_state got rs1 %0d tag %0d want 4 32", obs_rs1, obs_prd); end
  endtask

  task automatic test_random();
    rob_t e;
    logic v, wr, rv, fl;
    logic [4:0] a1, a2, d;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 3) != 0);
      d  = 5'($urandom_range(0, 31));
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      rv = (rob_q.size() != 0) && ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) == 0);
      if (rv) begin
        e = rob_q[0];
        cycle(v, a1, a2, d, wr, 1, 1, e.arch, e.phys, e.prev, fl);
      end else begin
        cycle(v, a1, a2, d, wr, 0, 0, 0, 0, 0, fl);
      end
      checks++;
      if (obs_ready !== exp_ready || obs_rs1 !== exp_rs1 || obs_rs2 !== exp_rs2 || obs_prev !== exp_prev) begin
        errors++;
        $display("FAIL random_%0d_comb got rdy %0b rs1 %0d rs2 %0d prev %0d want rdy %0b rs1 %0d rs2 %0d prev %0d",
                 n, obs_ready, obs_rs1, obs_rs2, obs_prev, exp_ready, exp_rs1, exp_rs2, exp_prev);
      end
      if (exp_prd_known) begin
        checks++;
        if (obs_prd !== exp_prd) begin errors++; $display("FAIL random_%0d_phys_rd got %0d want %0d", n, obs_prd, exp_prd); end
      end
      checks++;
      if (obs_fc !== exp_fc || obs_err !== exp_err) begin
        errors++; $display("FAIL random_%0d_state got fc %0d err %0b want fc %0d err %0b", n, obs_fc, obs_err, exp_fc, exp_err);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    test_reset();
    test_basic_rename();
    test_exhaust_and_refill();
    test_flush_recovery();
    test_flush_with_retire();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
